// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen
// Programmable phase-sweep generator that feeds the cordic angle input.
// A phase accumulator starts at a configured offset and advances by a
// configured step once per clock, for a configured number of samples.
// The top DW bits of the accumulator are presented on z_tgt.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cfg_valid  config word present
//   cfg_ready  config accepted this cycle (IDLE only, low during reset)
//   cfg_step   phase increment per sample (AW bits)
//   cfg_offset starting phase (AW bits)
//   cfg_count  number of samples to emit (CW bits)
//   start      begin a sweep (honoured in IDLE only)
//   abort      terminate a running sweep, no done pulse
//   z_tgt      angle to the cordic, held outside a sweep
//   z_valid    z_tgt carries a sweep sample this cycle
//   busy       sweep in progress
//   done       one-cycle pulse after the last sample of a completed sweep
//
// Optional build macro: CORDIC_PG_DITHER_EN adds a 16-bit LFSR dither
// (taps 16,14,13,11, seed 0xACE1) to the phase before truncation.
module cordic_phase_gen #(
  parameter int DW = 7,
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_step,
  input  logic [AW-1:0] cfg_offset,
  input  logic [CW-1:0] cfg_count,
  input  logic          start,
  input  logic          abort,
  output logic [DW-1:0] z_tgt,
  output logic          z_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] step_r;
  logic [AW-1:0] offset_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] acc_r;
  logic [CW-1:0] cnt_r;

  logic          xfer_s;
  logic [AW-1:0] eff_step_s;
  logic [AW-1:0] eff_offset_s;
  logic [CW-1:0] eff_count_s;
  logic [AW-1:0] acc_nxt_s;
  logic [DW-1:0] start_angle_s;
  logic [DW-1:0] run_angle_s;

  // Truncate a phase to the cordic angle width.
  function automatic logic [DW-1:0] to_angle(input logic [AW-1:0] ph);
    return ph[AW-1:AW-DW];
  endfunction

  // Config is only accepted in IDLE and never while reset is asserted.
  assign cfg_ready = rst_n & (state_r == ST_IDLE);

  // Effective config: a transfer in the same cycle as start takes priority.
  always_comb begin
    xfer_s = cfg_valid & cfg_ready;
    if (xfer_s) begin
      eff_step_s   = cfg_step;
      eff_offset_s = cfg_offset;
      eff_count_s  = cfg_count;
    end else begin
      eff_step_s   = step_r;
      eff_offset_s = offset_r;
      eff_count_s  = count_r;
    end
    acc_nxt_s = acc_r + step_r;
  end

`ifdef CORDIC_PG_DITHER_EN
  logic [15:0] lfsr_r;
  logic [15:0] dith_lfsr_s;

  // Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Dither source advances once per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= 16'hACE1;
    end else if (state_r == ST_RUN) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Samples formed in RUN use the value the LFSR moves to on that edge,
  // so every emitted sample sees a distinct dither word.
  always_comb begin
    if (state_r == ST_RUN) begin
      dith_lfsr_s = lfsr_next(lfsr_r);
    end else begin
      dith_lfsr_s = lfsr_r;
    end
    start_angle_s = to_angle(eff_offset_s + AW'(dith_lfsr_s[AW-DW-1:0]));
    run_angle_s   = to_angle(acc_nxt_s + AW'(dith_lfsr_s[AW-DW-1:0]));
  end
`else
  // Plain truncation of the undithered phase.
  always_comb begin
    start_angle_s = to_angle(eff_offset_s);
    run_angle_s   = to_angle(acc_nxt_s);
  end
`endif

  // Sweep control FSM with registered outputs; cnt_r counts samples still
  // to be shown including the one currently on z_tgt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      step_r   <= {AW{1'b0}};
      offset_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      acc_r    <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      z_tgt    <= {DW{1'b0}};
      z_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (xfer_s) begin
        step_r   <= cfg_step;
        offset_r <= cfg_offset;
        count_r  <= cfg_count;
      end
      case (state_r)
        ST_IDLE: begin
          done    <= 1'b0;
          z_valid <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            if (eff_count_s != {CW{1'b0}}) begin
              state_r <= ST_RUN;
              acc_r   <= eff_offset_s;
              cnt_r   <= eff_count_s;
              z_tgt   <= start_angle_s;
              z_valid <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Abort beats completion of the last sample.
            state_r <= ST_IDLE;
            z_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt_r == CW'(1)) begin
            state_r <= ST_DONE;
            cnt_r   <= {CW{1'b0}};
            z_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_r - CW'(1);
            z_tgt   <= run_angle_s;
            z_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          z_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen (DW=7, AW=16, CW=16, no dither).
// The reference model computes each expected angle directly as
// ((offset + k*step) mod 2^16) >> 9 from the configuration the bench holds.
module tb_cordic_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step;
  logic [15:0] cfg_offset;
  logic [15:0] cfg_count;
  logic        start;
  logic        abort;
  logic [6:0]  z_tgt;
  logic        z_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // model of the stored configuration
  int m_step = 0;
  int m_off  = 0;
  int m_cnt  = 0;

  cordic_phase_gen #(.DW(7), .AW(16), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_step  (cfg_step),
    .cfg_offset(cfg_offset),
    .cfg_count (cfg_count),
    .start     (start),
    .abort     (abort),
    .z_tgt     (z_tgt),
    .z_valid   (z_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_z(input int k);
    longint ph;
    ph = (longint'(m_off) + longint'(k) * longint'(m_step)) % 65536;
    return int'(ph / 512);
  endfunction

  task automatic load_cfg(input int st, input int of, input int cn);
    cfg_valid = 1'b1; cfg_step = 16'(st); cfg_offset = 16'(of); cfg_count = 16'(cn);
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    m_step = st; m_off = of; m_cnt = cn;
    chk("cfg_ready_after_cfg", {31'd0, cfg_ready}, 32'd1);
  endtask

  // One sweep: optional same-cycle config, optional abort / reset at a sample
  // index (-1 = none), optional cfg_valid noise while running.
  task automatic sweep(input bit load, input int st, input int of, input int cn,
                       input int abort_at, input int rst_at, input bit noise);
    int last;
    last = 0;
    cfg_valid = load; cfg_step = 16'(st); cfg_offset = 16'(of); cfg_count = 16'(cn);
    start = 1'b1;
    if (load) begin m_step = st; m_off = of; m_cnt = cn; end
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    if (m_cnt == 0) begin
      chk("zero_cnt_valid", {31'd0, z_valid}, 32'd0);
      chk("zero_cnt_done", {31'd0, done}, 32'd1);
      chk("zero_cnt_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("zero_cnt_done_off", {31'd0, done}, 32'd0);
      chk("zero_cnt_ready", {31'd0, cfg_ready}, 32'd1);
      return;
    end
    for (int k = 0; k < m_cnt; k++) begin
      chk("sample_valid", {31'd0, z_valid}, 32'd1);
      chk("sample_z", {25'd0, z_tgt}, 32'(exp_z(k)));
      chk("sample_busy", {31'd0, busy}, 32'd1);
      chk("sample_done", {31'd0, done}, 32'd0);
      chk("sample_ready", {31'd0, cfg_ready}, 32'd0);
      last = exp_z(k);
      if (k == rst_at) begin
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_ready_low", {31'd0, cfg_ready}, 32'd0);
        rst_n = 1'b1;
        chk("rst_z", {25'd0, z_tgt}, 32'd0);
        chk("rst_valid", {31'd0, z_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        m_step = 0; m_off = 0; m_cnt = 0;
        return;
      end
      if (k == abort_at) begin
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'd0, z_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_z_hold", {25'd0, z_tgt}, 32'(last));
        for (int j = 0; j < 3; j++) begin
          chk("abort_no_done", {31'd0, done}, 32'd0);
          chk("abort_ready", {31'd0, cfg_ready}, 32'd1);
          tick();
        end
        return;
      end
      if (noise && k < m_cnt - 1) begin
        cfg_valid = 1'($urandom);
        cfg_step = 16'($urandom); cfg_offset = 16'($urandom); cfg_count = 16'($urandom);
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0;
    chk("end_valid", {31'd0, z_valid}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_z_hold", {25'd0, z_tgt}, 32'(last));
    abort = 1'b1;   // abort in DONE has no effect
    tick();
    abort = 1'b0;
    chk("end_done_pulse", {31'd0, done}, 32'd0);
    chk("end_ready", {31'd0, cfg_ready}, 32'd1);
    chk("end_z_hold2", {25'd0, z_tgt}, 32'(last));
  endtask

  initial begin
    int st, of, cn, ab;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_step = 16'd0; cfg_offset = 16'd0;
    cfg_count = 16'd0; start = 1'b0; abort = 1'b0;
    tick();
    tick();
    chk("reset_ready", {31'd0, cfg_ready}, 32'd0);
    chk("reset_z", {25'd0, z_tgt}, 32'd0);
    chk("reset_valid", {31'd0, z_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", {31'd0, cfg_ready}, 32'd1);

    // basic sweep 0,4,...,124
    load_cfg(16'h0800, 0, 32);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b0);
    // wrap-around 120,124,0
    load_cfg(16'h0800, 16'hF000, 3);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b0);
    // abort on 5th sample
    load_cfg(16'h0800, 0, 32);
    sweep(1'b0, 0, 0, 0, 4, -1, 1'b0);
    // same-cycle config and start, then zero count
    sweep(1'b1, 16'h0200, 0, 4, -1, -1, 1'b0);
    load_cfg(16'h0200, 0, 0);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b0);
    // config rejection during run; later sweep reuses old config
    load_cfg(16'h0300, 16'h1234, 10);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b1);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b0);
    // reset mid-sweep at sample 10, stored config cleared, then restart
    load_cfg(16'h0800, 0, 32);
    sweep(1'b0, 0, 0, 0, -1, 10, 1'b0);
    sweep(1'b0, 0, 0, 0, -1, -1, 1'b0);
    sweep(1'b1, 16'h0800, 0, 32, -1, -1, 1'b0);
    // abort on last sample wins over completion
    sweep(1'b1, 16'h0100, 16'h0040, 3, 2, -1, 1'b0);

    // randomized sweeps
    for (int r = 0; r < 12; r++) begin
      st = int'($urandom_range(0, 65535));
      of = int'($urandom_range(0, 65535));
      cn = int'($urandom_range(0, 14));
      ab = ($urandom_range(0, 2) == 0 && cn > 0) ? int'($urandom_range(0, cn - 1)) : -1;
      if ($urandom_range(0, 1) == 1) begin
        sweep(1'b1, st, of, cn, ab, -1, 1'b1);
      end else begin
        load_cfg(st, of, cn);
        sweep(1'b0, 0, 0, 0, ab, -1, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
